conv2_feed_ctrl: RTL
====================

# conv2_feed_ctrl

Frame sequencer for the second convolution stage's 8-channel binary sliding-window buffer. On a start pulse it streams one 13x13 feature map (8 one-bit channels per pixel) from the pool-1 feature memory into the window buffer at one pixel per clock, with no gaps. It also tags each buffer output with its window position, marks only the 11x11 fully-populated windows valid, and signals frame completion to the layer controller.

## Interface
Parameters:
- WIDTH, 13, feature-map columns.
- HEIGHT, 13, feature-map rows.
- BUF_LAT, 2, cycles from `buf_pixel` sampled by the window buffer to the corresponding window appearing on its output.
- ADDR_W, 8, feature-memory address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to process one frame.
- busy  out  1  high from start acceptance until the `done` cycle inclusive.
- done  out  1  one-cycle pulse after the last window is tagged.
- feat_rd_en  out  1  feature-memory read strobe.
- feat_rd_addr  out  ADDR_W  pixel index, row-major (r*WIDTH+c).
- feat_rd_data  in  8  memory data; valid exactly 1 cycle after `feat_rd_en`.
- buf_pixel  out  8  pixel into the window buffer (bit i = channel i).
- win_valid  out  1  window-buffer output this cycle is a complete 3x3 window.
- win_row  out  4  row of the window's bottom-right pixel (2..HEIGHT-1 when valid).
- win_col  out  4  column of the window's bottom-right pixel (2..WIDTH-1 when valid).
- win_last  out  1  with `win_valid`: final window of the frame (row = HEIGHT-1, col = WIDTH-1).

## Operation
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE: `start` moves the FSM to FETCH, clears the row/column counters and raises `busy`. `start` is ignored in every other state (no queueing).
- FETCH: asserts `feat_rd_en` every cycle. Address counter runs 0..WIDTH*HEIGHT-1. Column counter wraps at WIDTH-1 and increments the row counter. After issuing index WIDTH*HEIGHT-1, the FSM moves to DRAIN.
- Data path: `buf_pixel` <= `feat_rd_data` one cycle after the read returns. Outside an active stream, `buf_pixel` <= 8'h00.
- Tag pipeline: {strm, row, col} enters at the address-issue cycle. Its delay is 2 + BUF_LAT so it aligns with the buffer output.
  - `win_valid` = strm & row>=2 & col>=2.
  - `win_last` = `win_valid` & row==HEIGHT-1 & col==WIDTH-1.
  - Windows with col<2 straddle a row wrap; windows with row<2 hold stale lines from the previous frame. Both are masked.
- DRAIN: no reads. Waits until the tag carrying `win_last` has been output, then moves to DONE.
- DONE: `done`=1 for one cycle, then IDLE (`busy` drops the next cycle). A `start` in the DONE cycle is ignored.
- Per frame: exactly WIDTH*HEIGHT reads and (WIDTH-2)*(HEIGHT-2) = 121 valid windows.
- The stream is never stalled; the window buffer has no enable, so downstream must accept one window per cycle.

## Timing
- Reset values: state IDLE; `busy`, `done`, `feat_rd_en`, `win_valid`, `win_last` = 0; `feat_rd_addr`, `buf_pixel`, `win_row`, `win_col` = 0. Tag pipeline is cleared.
- Start accepted in cycle T: first `feat_rd_en` in T+1 (addr 0); last read in T+WIDTH*HEIGHT (addr 168).
- Pixel index k: read at T+1+k, `buf_pixel` at T+3+k, window tag at T+3+k+BUF_LAT.
- First `win_valid` (row 2, col 2, k=28) at T+31+BUF_LAT; `win_last` (k=168) at T+171+BUF_LAT; `done` one cycle later. Defaults: first at T+33, last at T+173, `done` at T+174.
- Reset asserted mid-frame: all outputs return to reset values immediately. No `done` is issued. The next frame starts cleanly because stale rows are masked.
- `win_row`/`win_col` are don't-care when `win_valid`=0 but must be driven, never X.

## Structure
- Shared layer package: FEAT_W=13, FEAT_H=13, NUM_CH=8, BUF_LAT, the state enum, and the pixel-index/row/col widths.
- One sub-module: `tag_delay`, a parameterised-depth shift register for {strm,row,col}, cleared on reset.
- Controller FSM and counters stay in the top module.

## Test plan
- Reset then one start with memory word k = k[7:0]:
  - exactly 169 reads, addr 0..168, contiguous;
  - 121 `win_valid`, first at T+33 with row 2/col 2, `win_last` at T+173 with row 12/col 12, `done` at T+174;
  - `buf_pixel` equals the expected word at T+3+k.
- Pulse start every cycle during a frame: ignored; still 169 reads, one `done`.
- Two frames back-to-back (start the cycle after `busy` falls), frame 2 data = ~k: no `win_valid` for row<2 of frame 2; counts repeat exactly.
- Assert `rst_n` low at T+80 for 2 cycles: outputs are 0 during reset; no `done`; a new start yields a full correct frame.
- Column-wrap check: no `win_valid` at col 0/1 of any row; `win_valid` count per row = 11 for rows 2..12.
- Idle: with no start for 500 cycles, `feat_rd_en`, `win_valid`, `busy` stay 0 and `buf_pixel`=8'h00.

Source files
------------

// File: rtl/conv2_feed_ctrl_pkg.sv
// Shared constants and types for the conv-2 feature feed: map geometry,
// channel count, window-buffer latency, controller states and the window tag.
package conv2_feed_ctrl_pkg;

    localparam int unsigned FEAT_W    = 13;
    localparam int unsigned FEAT_H    = 13;
    localparam int unsigned NUM_CH    = 8;
    localparam int unsigned BUF_LAT   = 2;

    localparam int unsigned PIX_IDX_W = 8;
    localparam int unsigned ROW_W     = 4;
    localparam int unsigned COL_W     = 4;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic             strm;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } tag_t;

endpackage

// File: rtl/conv2_feed_ctrl_tag_delay.sv
// Fixed-depth shift register that carries the {strm,row,col} window tag
// alongside the read/buffer pipeline; every stage clears on reset.
module tag_delay #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] sr_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                sr_q[i] <= '0;
            end
        end else begin
            sr_q[0] <= d_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                sr_q[i] <= sr_q[i-1];
            end
        end
    end

    assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/conv2_feed_ctrl.sv
// Conv-2 frame sequencer: streams one feature map into the window buffer at a
// pixel per clock and tags each buffer output with its window position.
module conv2_feed_ctrl
    import conv2_feed_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH   = FEAT_W,
    parameter int unsigned HEIGHT  = FEAT_H,
    parameter int unsigned BUF_LAT = conv2_feed_ctrl_pkg::BUF_LAT,
    parameter int unsigned ADDR_W  = PIX_IDX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              feat_rd_en,
    output logic [ADDR_W-1:0] feat_rd_addr,
    input  logic [NUM_CH-1:0] feat_rd_data,
    output logic [NUM_CH-1:0] buf_pixel,
    output logic              win_valid,
    output logic [ROW_W-1:0]  win_row,
    output logic [COL_W-1:0]  win_col,
    output logic              win_last
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam logic [ROW_W-1:0]  ROW_MAX   = ROW_W'(HEIGHT - 1);
    localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(WIDTH - 1);

    state_t            state_q;
    logic              busy_q;
    logic              done_q;
    logic              rd_en_q;
    logic              rd_ret_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ROW_W-1:0]  row_q;
    logic [COL_W-1:0]  col_q;
    logic [NUM_CH-1:0] pix_q;
    tag_t              tag_in;
    tag_t              tag_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= FETCH;
                        busy_q  <= 1'b1;
                        rd_en_q <= 1'b1;
                        addr_q  <= '0;
                        row_q   <= '0;
                        col_q   <= '0;
                    end
                end
                FETCH: begin
                    if (addr_q == LAST_ADDR) begin
                        rd_en_q <= 1'b0;
                        state_q <= DRAIN;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                        if (col_q == COL_MAX) begin
                            col_q <= '0;
                            row_q <= row_q + 1'b1;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (win_last) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Memory answers one cycle after the strobe; the pixel is registered once more.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ret_q <= 1'b0;
            pix_q    <= '0;
        end else begin
            rd_ret_q <= rd_en_q;
            pix_q    <= rd_ret_q ? feat_rd_data : '0;
        end
    end

    assign tag_in = '{strm: rd_en_q, row: row_q, col: col_q};

    tag_delay #(
        .DEPTH (2 + BUF_LAT),
        .W     ($bits(tag_t))
    ) u_tag_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (tag_in),
        .q_o   (tag_out)
    );

    // Column < 2 straddles a row wrap; row < 2 still holds the previous frame.
    assign win_valid = tag_out.strm && (tag_out.row >= ROW_W'(2)) && (tag_out.col >= COL_W'(2));
    assign win_last  = win_valid && (tag_out.row == ROW_MAX) && (tag_out.col == COL_MAX);
    assign win_row   = tag_out.row;
    assign win_col   = tag_out.col;

    assign busy         = busy_q;
    assign done         = done_q;
    assign feat_rd_en   = rd_en_q;
    assign feat_rd_addr = addr_q;
    assign buf_pixel    = pix_q;

endmodule
